// File: rtl/debounced_edge_detector_pkg.sv
// Shared constants for the debounced edge detector and its synchroniser.
package debounced_edge_detector_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;

endpackage : debounced_edge_detector_pkg

// File: rtl/debounced_edge_detector_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. Both flops reset to
// RESET_LEVEL so an idle line does not look like a transition after reset.
module sync_2ff #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_low,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule : sync_2ff

// File: rtl/debounced_edge_detector.sv
// Synchronise, debounce and edge-detect one noisy asynchronous input line.
// level flips only after CYCLES consecutive edges of disagreement.
module debounced_edge_detector
  import debounced_edge_detector_pkg::*;
#(
  parameter int unsigned CYCLES      = 255,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_low,
  input  logic bit_in,
  output logic level,
  output logic pos_edge,
  output logic neg_edge,
  output logic any_edge
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES - 1);

  logic             sync_bit;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;
  logic             level_prev_q;

  sync_2ff #(
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk       (clk),
    .reset_low (reset_low),
    .d_i       (bit_in),
    .q_o       (sync_bit)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = '0;
    level_d = level_q;
    if (sync_bit == level_q) begin
      count_d = '0;
    end else if (count_q == LAST_COUNT) begin
      level_d = sync_bit;
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: the async reset clears the partial count too, so a reset in the
  // middle of a debounce window can never release straight into an edge.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      count_q      <= '0;
      level_q      <= RESET_LEVEL;
      level_prev_q <= RESET_LEVEL;
    end else begin
      count_q      <= count_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  // Strobes are high only in the first cycle level shows its new value.
  assign level    = level_q;
  assign pos_edge = (level_q == HIGH) && (level_prev_q == LOW);
  assign neg_edge = (level_q == LOW)  && (level_prev_q == HIGH);
  assign any_edge = pos_edge | neg_edge;

endmodule : debounced_edge_detector

// File: tb/tb_debounced_edge_detector.sv
// Directed bench: dut_a runs CYCLES=4 for the short scenarios, dut_b runs the
// default CYCLES=255 for reset-mid-count and full-latency scenarios.
module tb_debounced_edge_detector;
  import debounced_edge_detector_pkg::*;

  logic clk = 1'b0;
  logic reset_a, bit_a, level_a, pos_a, neg_a, any_a;
  logic reset_b, bit_b, level_b, pos_b, neg_b, any_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounced_edge_detector #(.CYCLES(4), .RESET_LEVEL(1'b1)) dut_a (
    .clk       (clk),
    .reset_low (reset_a),
    .bit_in    (bit_a),
    .level     (level_a),
    .pos_edge  (pos_a),
    .neg_edge  (neg_a),
    .any_edge  (any_a)
  );

  debounced_edge_detector #(.CYCLES(255), .RESET_LEVEL(1'b1)) dut_b (
    .clk       (clk),
    .reset_low (reset_b),
    .bit_in    (bit_b),
    .level     (level_b),
    .pos_edge  (pos_b),
    .neg_edge  (neg_b),
    .any_edge  (any_b)
  );

  // Advance one rising edge and settle; outputs are read and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    reset_a = 1'b0; reset_b = 1'b0;
    bit_a = 1'b0;   bit_b = 1'b0;
    #2;
    repeat (3) tick();
    obs = {level_a, pos_a, neg_a, any_a};
    n_cmp++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_hold_a: got %b want 1000", obs);
    end
    obs = {level_b, pos_b, neg_b, any_b};
    n_cmp++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_hold_b: got %b want 1000", obs);
    end
    bit_a = 1'b1; bit_b = 1'b1;
    tick();
    reset_a = 1'b1; reset_b = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      obs = {level_a, pos_a, neg_a, any_a};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_release_a cyc %0d: got %b want 1000", i, obs);
      end
      obs = {level_b, pos_b, neg_b, any_b};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_release_b cyc %0d: got %b want 1000", i, obs);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [3:0] obs, exp;
    logic       e_lvl, e_str;
    bit_a = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e_lvl = (i >= 6) ? LOW : HIGH;
      e_str = (i == 6) ? YES : NO;
      exp = {e_lvl, NO, e_str, e_str};
      obs = {level_a, pos_a, neg_a, any_a};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL clean_fall cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    bit_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e_lvl = (i >= 6) ? HIGH : LOW;
      e_str = (i == 6) ? YES : NO;
      exp = {e_lvl, e_str, NO, e_str};
      obs = {level_a, pos_a, neg_a, any_a};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL clean_rise cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] obs;
    for (int i = 0; i < 26; i++) begin
      for (int j = 0; j < 4; j++) begin
        bit_a = (j < 3) ? LOW : HIGH;
        tick();
        obs = {level_a, pos_a, neg_a, any_a};
        n_cmp++;
        if (obs !== 4'b1000) begin
          n_err++;
          $display("FAIL glitch burst %0d step %0d: got %b want 1000", i, j, obs);
        end
      end
    end
    bit_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      obs = {level_a, pos_a, neg_a, any_a};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL glitch_tail cyc %0d: got %b want 1000", i, obs);
      end
    end
  endtask

  task automatic test_threshold();
    logic [3:0] obs, exp;
    logic       e_lvl, e_pos, e_neg;
    for (int i = 1; i <= 18; i++) begin
      bit_a = (i <= 4) ? LOW : HIGH;
      if (i == 1) #0;
      tick();
      e_lvl = (i >= 6 && i <= 9) ? LOW : HIGH;
      e_pos = (i == 10) ? YES : NO;
      e_neg = (i == 6)  ? YES : NO;
      exp = {e_lvl, e_pos, e_neg, e_pos | e_neg};
      obs = {level_a, pos_a, neg_a, any_a};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL threshold cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, exp;
    logic       e_lvl, e_str;
    bit_b = 1'b0;
    repeat (200) tick();
    obs = {level_b, pos_b, neg_b, any_b};
    n_cmp++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid_precount: got %b want 1000", obs);
    end
    reset_b = 1'b0;
    tick();
    obs = {level_b, pos_b, neg_b, any_b};
    n_cmp++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid_inreset: got %b want 1000", obs);
    end
    reset_b = 1'b1;
    for (int i = 1; i <= 262; i++) begin
      tick();
      e_lvl = (i >= 257) ? LOW : HIGH;
      e_str = (i == 257) ? YES : NO;
      exp = {e_lvl, NO, e_str, e_str};
      obs = {level_b, pos_b, neg_b, any_b};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_default_latency();
    logic [3:0] obs, exp;
    logic       e_lvl, e_str;
    bit_b = 1'b1;
    for (int i = 1; i <= 262; i++) begin
      tick();
      e_lvl = (i >= 257) ? HIGH : LOW;
      e_str = (i == 257) ? YES : NO;
      exp = {e_lvl, e_str, NO, e_str};
      obs = {level_b, pos_b, neg_b, any_b};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL latency_rise cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    bit_b = 1'b0;
    for (int i = 1; i <= 262; i++) begin
      tick();
      e_lvl = (i >= 257) ? LOW : HIGH;
      e_str = (i == 257) ? YES : NO;
      exp = {e_lvl, NO, e_str, e_str};
      obs = {level_b, pos_b, neg_b, any_b};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL latency_fall cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_glitch();
    test_threshold();
    test_reset_mid();
    test_default_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_debounced_edge_detector
